// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB types and buffer sizing constants
package usb_pkg;

   localparam int BUFFER_DEPTH  = 64;
   localparam int BUFFER_ADDR_W = 6;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DATA = 2'b01,
      ACK  = 2'b10,
      NAK  = 2'b11
   } tx_packet_t;

endpackage

// File: rtl/usb_data_buffer_if.sv
// rtl/usb_data_buffer_if.sv - push/pop strobes, head bytes and status of the shared buffer
interface usb_data_buffer_if
   import usb_pkg::*;
#(
   parameter int CNT_W = 7
) ();

   logic             flush;
   logic             store_tx_data;
   byte_t            tx_data;
   logic             store_rx_packet_data;
   byte_t            rx_packet_data;
   logic             get_tx_packet;
   logic             get_rx_data;
   byte_t            tx_packet_data;
   byte_t            rx_data;
   logic [CNT_W-1:0] buffer_occupancy;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, store_tx_data, tx_data, store_rx_packet_data, rx_packet_data,
             get_tx_packet, get_rx_data,
      input  tx_packet_data, rx_data, buffer_occupancy, full, empty, overflow, underflow
   );

   modport slave (
      input  flush, store_tx_data, tx_data, store_rx_packet_data, rx_packet_data,
             get_tx_packet, get_rx_data,
      output tx_packet_data, rx_data, buffer_occupancy, full, empty, overflow, underflow
   );

endinterface

// File: rtl/usb_buffer_mem.sv
// rtl/usb_buffer_mem.sv - byte register file, synchronous write, combinational read
module usb_buffer_mem
   import usb_pkg::*;
#(
   parameter int DEPTH  = BUFFER_DEPTH,
   parameter int ADDR_W = BUFFER_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  byte_t             wdata,
   input  logic [ADDR_W-1:0] raddr,
   output byte_t             rdata
);

   byte_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// rtl/usb_data_buffer.sv - half-duplex byte FIFO shared by the AHB slave, usb_rx and usb_tx
module usb_data_buffer
   import usb_pkg::*;
#(
   parameter int DEPTH  = BUFFER_DEPTH,
   parameter int ADDR_W = BUFFER_ADDR_W,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic          clk,
   input  logic          rst,
   usb_data_buffer_if.slave bus
);

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [CNT_W-1:0]  count;
   logic              overflow_q;
   logic              underflow_q;

   logic  push;
   logic  pop;
   logic  is_empty;
   logic  is_full;
   logic  do_pop;
   logic  do_push;
   logic  mem_we;
   byte_t wdata;
   byte_t head;

   assign push     = bus.store_tx_data | bus.store_rx_packet_data;
   assign pop      = bus.get_tx_packet | bus.get_rx_data;
   assign wdata    = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;
   assign is_empty = (count == '0);
   assign is_full  = (count == CNT_W'(DEPTH));

   // A pop on a full buffer frees the slot the simultaneous push lands in.
   assign do_pop  = pop & ~is_empty;
   assign do_push = push & (~is_full | do_pop);
   assign mem_we  = do_push & ~rst & ~bus.flush;

   usb_buffer_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wptr),
      .wdata (wdata),
      .raddr (rptr),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
         // Two writers in one cycle lose the TX byte, which counts as a drop.
         if ((push && !do_push) || (bus.store_tx_data && bus.store_rx_packet_data)) begin
            overflow_q <= 1'b1;
         end
         if (pop && is_empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.tx_packet_data   = is_empty ? 8'h00 : head;
   assign bus.rx_data          = is_empty ? 8'h00 : head;
   assign bus.buffer_occupancy = count;
   assign bus.full             = is_full;
   assign bus.empty            = is_empty;
   assign bus.overflow         = overflow_q;
   assign bus.underflow        = underflow_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb/tb_usb_data_buffer.sv - directed and random checks of usb_data_buffer against a queue model
module tb_usb_data_buffer;
   import usb_pkg::*;

   logic tb_clk = 1'b0;
   logic rst;

   usb_data_buffer_if #(.CNT_W(7)) bus ();

   usb_data_buffer #(.DEPTH(64), .ADDR_W(6), .CNT_W(7)) dut (
      .clk (tb_clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 tb_clk = ~tb_clk;

   byte_t q[$];
   logic  m_ov;
   logic  m_uf;
   byte_t seen;
   int    checks;
   int    failures;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("occupancy", 32'(bus.buffer_occupancy), q.size());
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("full", 32'(bus.full), 32'(q.size() == 64));
      chk("tx_head", 32'(bus.tx_packet_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      chk("rx_head", 32'(bus.rx_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      chk("overflow", 32'(bus.overflow), 32'(m_ov));
      chk("underflow", 32'(bus.underflow), 32'(m_uf));
   endtask

   task automatic cycle(input logic stx, input byte_t txd, input logic srx, input byte_t rxd,
                        input logic gtx, input logic grx, input logic fl, input logic r);
      logic popped;
      logic pushed;
      @(negedge tb_clk);
      bus.store_tx_data        = stx;
      bus.tx_data              = txd;
      bus.store_rx_packet_data = srx;
      bus.rx_packet_data       = rxd;
      bus.get_tx_packet        = gtx;
      bus.get_rx_data          = grx;
      bus.flush                = fl;
      rst                      = r;
      #1;
      if (!r && !fl && (gtx || grx) && q.size() > 0) begin
         seen = bus.tx_packet_data;
         chk("pop_head", 32'(seen), 32'(q[0]));
      end
      if (r || fl) begin
         q.delete();
         m_ov = 1'b0;
         m_uf = 1'b0;
      end else begin
         popped = (gtx || grx) && q.size() > 0;
         pushed = 1'b0;
         if ((gtx || grx) && q.size() == 0) m_uf = 1'b1;
         if (stx && srx) m_ov = 1'b1;
         if (stx || srx) begin
            if (q.size() < 64 || popped) pushed = 1'b1;
            else m_ov = 1'b1;
         end
         if (popped) void'(q.pop_front());
         if (pushed) q.push_back(srx ? rxd : txd);
      end
      @(posedge tb_clk);
      #1;
      check_all();
   endtask

   task automatic push_tx(input byte_t d);
      cycle(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_tx();
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      byte_t exp_tx[3];
      checks   = 0;
      failures = 0;
      m_ov     = 1'b0;
      m_uf     = 1'b0;
      seen     = 8'h00;
      exp_tx   = '{8'hAA, 8'hFE, 8'h01};
      bus.store_tx_data = 1'b0; bus.tx_data = 8'h00;
      bus.store_rx_packet_data = 1'b0; bus.rx_packet_data = 8'h00;
      bus.get_tx_packet = 1'b0; bus.get_rx_data = 1'b0;
      bus.flush = 1'b0; rst = 1'b1;

      // Reset
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_occ", 32'(bus.buffer_occupancy), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_head", 32'(bus.tx_packet_data), 0);

      // TX path
      for (int i = 0; i < 3; i++) push_tx(exp_tx[i]);
      chk("tx_occ3", 32'(bus.buffer_occupancy), 3);
      chk("tx_headAA", 32'(bus.tx_packet_data), 32'hAA);
      for (int i = 0; i < 3; i++) begin
         pop_tx();
         chk("tx_seen", 32'(seen), 32'(exp_tx[i]));
      end
      chk("tx_empty", 32'(bus.empty), 1);
      chk("tx_head00", 32'(bus.tx_packet_data), 0);

      // Full and wrap
      for (int i = 0; i < 64; i++) push_tx(byte_t'(i));
      chk("full_flag", 32'(bus.full), 1);
      push_tx(8'h55);
      chk("drop_ov", 32'(bus.overflow), 1);
      chk("drop_occ", 32'(bus.buffer_occupancy), 64);
      for (int i = 0; i < 64; i++) begin
         pop_tx();
         chk("wrap_order", 32'(seen), i);
      end

      // Simultaneous push/pop when full, then when empty
      for (int i = 0; i < 64; i++) push_tx(byte_t'(i + 100));
      cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fullpp_occ", 32'(bus.buffer_occupancy), 64);
      for (int i = 0; i < 64; i++) pop_tx();
      chk("fullpp_last", 32'(seen), 32'h77);
      cycle(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("emptypp_uf", 32'(bus.underflow), 1);
      chk("emptypp_occ", 32'(bus.buffer_occupancy), 1);
      chk("emptypp_head", 32'(bus.tx_packet_data), 32'h33);

      // Collision of writers and of readers
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("coll_head", 32'(bus.rx_data), 32'h22);
      chk("coll_ov", 32'(bus.overflow), 1);
      push_tx(8'h44);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("dualpop_occ", 32'(bus.buffer_occupancy), 1);
      chk("dualpop_head", 32'(bus.rx_data), 32'h44);

      // Flush and reset mid-operation
      for (int i = 0; i < 10; i++) push_tx(byte_t'(8'hC0 + i));
      cycle(1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("flush_occ", 32'(bus.buffer_occupancy), 0);
      chk("flush_ov", 32'(bus.overflow), 0);
      for (int i = 0; i < 10; i++) push_tx(byte_t'(8'hD0 + i));
      pop_tx();
      pop_tx();
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rstmid_occ", 32'(bus.buffer_occupancy), 0);
      chk("rstmid_head", 32'(bus.tx_packet_data), 0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         int bias;
         bias = (n / 100) % 2 ? 70 : 30;
         cycle(($urandom_range(0, 99) < bias), byte_t'($urandom),
               ($urandom_range(0, 99) < 15), byte_t'($urandom),
               ($urandom_range(0, 99) < 100 - bias), ($urandom_range(0, 99) < 10),
               ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) < 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
